// File: rtl/dcache_port_ctrl.sv
// dcache_port_ctrl
//   Data-cache-side responder for the memory port that is shared by the store
//   queue and the load unit. It arbitrates between the two requesters and
//   performs fixed-latency reads and writes into a word-addressed data array.
//   Loads win by default. A store that keeps losing is granted once it has
//   lost STARVE_LIM times in a row, so the store queue always drains.
//
// Ports
//   clk       clock, all state updates on the rising edge
//   rst       synchronous active-low reset
//   str_req   store queue has a committed store at its head
//   addr_str  store address, valid with str_req
//   data_ca   store data, valid with str_req
//   str_grnt  one-cycle pulse: store accepted, addr_str/data_ca sampled
//   done      one-cycle pulse: store written to the array
//   ld_req    load request
//   addr_ld   load address, valid with ld_req
//   ld_grnt   one-cycle pulse: load accepted, addr_ld sampled
//   ld_vld    one-cycle pulse: ld_data valid
//   ld_data   load result, holds its last value between loads
//   busy      access in progress (or being granted this cycle)
//
// Only the low MEM_AW address bits index the array, so ADDR_W must exceed
// MEM_AW; the upper address bits alias onto the same words.

module dcache_port_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_AW     = 8,
  parameter int LAT        = 2,
  parameter int STARVE_LIM = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              str_req,
  input  logic [ADDR_W-1:0] addr_str,
  input  logic [DATA_W-1:0] data_ca,
  output logic              str_grnt,
  output logic              done,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] addr_ld,
  output logic              ld_grnt,
  output logic              ld_vld,
  output logic [DATA_W-1:0] ld_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STORE,
    REC
  } state_t;

  localparam logic [3:0] LAT_INIT   = 4'(LAT - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        lat_cnt;
  logic [3:0]        lat_nxt;
  logic [3:0]        starve_cnt;
  logic [3:0]        starve_nxt;
  logic [MEM_AW-1:0] idx;
  logic [DATA_W-1:0] wdata;
  logic [MEM_AW-1:0] rd_idx;
  logic              ld_fill;

  logic [DATA_W-1:0] mem [0:(1 << MEM_AW) - 1];

  // Upper address bits only alias; they are collected here so they are
  // visibly consumed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_str[ADDR_W-1:MEM_AW], addr_ld[ADDR_W-1:MEM_AW]};

  // Arbitration, latency countdown and output pulses. Everything is gated by
  // rst, so no grant or completion pulse can appear while reset is asserted;
  // an access interrupted by reset therefore never signals done or ld_vld.
  always_comb begin
    state_nxt  = state;
    lat_nxt    = lat_cnt;
    starve_nxt = starve_cnt;
    str_grnt   = 1'b0;
    ld_grnt    = 1'b0;
    done       = 1'b0;
    ld_vld     = 1'b0;
    if (rst) begin
      case (state)
        IDLE: begin
          if (str_req && (!ld_req || starve_cnt >= STARVE_MAX)) begin
            str_grnt   = 1'b1;
            starve_nxt = 4'd0;
            lat_nxt    = LAT_INIT;
            state_nxt  = STORE;
          end else if (ld_req) begin
            ld_grnt   = 1'b1;
            lat_nxt   = LAT_INIT;
            state_nxt = LOAD;
            // Reaching here with str_req high means the store lost while
            // still below the limit.
            if (str_req) begin
              starve_nxt = starve_cnt + 4'd1;
            end
          end
        end
        LOAD: begin
          if (lat_cnt == 4'd0) begin
            ld_vld    = 1'b1;
            state_nxt = IDLE;
          end else begin
            lat_nxt = lat_cnt - 4'd1;
          end
        end
        STORE: begin
          if (lat_cnt == 4'd0) begin
            done      = 1'b1;
            state_nxt = REC;
          end else begin
            lat_nxt = lat_cnt - 4'd1;
          end
        end
        REC: begin
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // busy also covers the grant cycle itself, so a requester sees the port as
  // occupied from the moment it is accepted until the turnaround ends.
  assign busy = rst && ((state != IDLE) || str_grnt || ld_grnt);

  // The array read is registered one cycle early so ld_data is already valid
  // in the completion cycle. With LAT==1 that early cycle is the grant cycle,
  // where the index comes straight from addr_ld instead of the latch.
  assign ld_fill = (ld_grnt && (LAT == 1)) || (state == LOAD && lat_cnt == 4'd1);
  assign rd_idx  = ld_grnt ? addr_ld[MEM_AW-1:0] : idx;

  // Control state and the load result register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      lat_cnt    <= 4'd0;
      starve_cnt <= 4'd0;
      ld_data    <= '0;
    end else begin
      state      <= state_nxt;
      lat_cnt    <= lat_nxt;
      starve_cnt <= starve_nxt;
      if (ld_fill) begin
        ld_data <= mem[rd_idx];
      end
    end
  end

  // Request capture at grant time; the requester may move on afterwards.
  always_ff @(posedge clk) begin
    if (str_grnt) begin
      idx   <= addr_str[MEM_AW-1:0];
      wdata <= data_ca;
    end else if (ld_grnt) begin
      idx <= addr_ld[MEM_AW-1:0];
    end
  end

  // Array write at the end of the store completion cycle.
  always_ff @(posedge clk) begin
    if (done) begin
      mem[idx] <= wdata;
    end
  end

endmodule

// File: tb/tb_dcache_port_ctrl.sv
// tb_dcache_port_ctrl
//   Directed bench for dcache_port_ctrl. A monitor turns every observed grant
//   into an expected completion (cycle and, for loads, data taken from a
//   reference copy of the array) and pops those expectations when done/ld_vld
//   are due. The directed sequence checks reset, arbitration order and grant
//   spacing.

module tb_dcache_port_ctrl;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int MEM_AW     = 8;
  localparam int LAT        = 2;
  localparam int STARVE_LIM = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              str_req = 1'b0;
  logic [ADDR_W-1:0] addr_str = '0;
  logic [DATA_W-1:0] data_ca = '0;
  logic              str_grnt;
  logic              done;
  logic              ld_req = 1'b0;
  logic [ADDR_W-1:0] addr_ld = '0;
  logic              ld_grnt;
  logic              ld_vld;
  logic [DATA_W-1:0] ld_data;
  logic              busy;

  always #5 clk = ~clk;

  dcache_port_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW),
    .LAT(LAT), .STARVE_LIM(STARVE_LIM)
  ) dut (
    .clk(clk), .rst(rst),
    .str_req(str_req), .addr_str(addr_str), .data_ca(data_ca),
    .str_grnt(str_grnt), .done(done),
    .ld_req(ld_req), .addr_ld(addr_ld), .ld_grnt(ld_grnt),
    .ld_vld(ld_vld), .ld_data(ld_data), .busy(busy)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
    bit                known;
  } ld_exp_t;

  typedef struct {
    logic [MEM_AW-1:0] idx;
    logic [DATA_W-1:0] data;
    int                due;
  } st_exp_t;

  ld_exp_t           ldQ[$];
  st_exp_t           stQ[$];
  logic [DATA_W-1:0] model [0:(1 << MEM_AW) - 1];
  bit                modelKnown [0:(1 << MEM_AW) - 1];
  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: completions first, then new grants of this cycle.
  always @(negedge clk) begin : monitor
    bit      expDone;
    bit      expVld;
    ld_exp_t le;
    st_exp_t se;
    if (!rst) begin
      ldQ.delete();
      stQ.delete();
    end else begin
      expDone = (stQ.size() > 0) && (stQ[0].due == cyc);
      checkOutput("done", done, expDone);
      if (expDone) begin
        se = stQ.pop_front();
        model[se.idx]      = se.data;
        modelKnown[se.idx] = 1'b1;
      end
      expVld = (ldQ.size() > 0) && (ldQ[0].due == cyc);
      checkOutput("ld_vld", ld_vld, expVld);
      if (expVld) begin
        le = ldQ.pop_front();
        if (le.known) checkOutput("ld_data", ld_data, le.data);
      end
      checkOutput("grant_exclusive", ld_grnt & str_grnt, 0);
      if (ld_grnt) begin
        ldQ.push_back(ld_exp_t'{model[addr_ld[MEM_AW-1:0]], cyc + LAT,
                                modelKnown[addr_ld[MEM_AW-1:0]]});
      end
      if (str_grnt) begin
        stQ.push_back(st_exp_t'{addr_str[MEM_AW-1:0], data_ca, cyc + LAT});
      end
    end
  end

  task automatic applyStimulus(input logic s, input logic [ADDR_W-1:0] as,
                               input logic [DATA_W-1:0] d, input logic l,
                               input logic [ADDR_W-1:0] al);
    str_req  = s;
    addr_str = as;
    data_ca  = d;
    ld_req   = l;
    addr_ld  = al;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitGrant(input bit isStore, input int budget, output int gcyc);
    bit found;
    found = 1'b0;
    gcyc  = -1;
    for (int k = 0; k < budget && !found; k++) begin
      @(negedge clk);
      if (isStore ? str_grnt : ld_grnt) begin
        found = 1'b1;
        gcyc  = cyc;
      end
    end
    checkOutput(isStore ? "str_grant_seen" : "ld_grant_seen", found, 1);
  endtask

  task automatic waitDrain(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (ldQ.size() == 0 && stQ.size() == 0) break;
    end
    checkOutput("scoreboard_drained", ldQ.size() + stQ.size(), 0);
  endtask

  task automatic doLoad(input logic [ADDR_W-1:0] a);
    int g;
    applyStimulus(1'b0, '0, '0, 1'b1, a);
    waitGrant(1'b0, 8, g);
    nextCycle();
    ld_req = 1'b0;
    waitDrain(LAT + 4);
  endtask

  task automatic doStore(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int g;
    applyStimulus(1'b1, a, d, 1'b0, '0);
    waitGrant(1'b1, 8, g);
    nextCycle();
    str_req = 1'b0;
    waitDrain(LAT + 4);
    nextCycle();
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int g;
    int g1;
    int g2;
    int n;
    bit isStoreSeq [6];
    int grantCyc [6];
    bit expSeq [6];

    // Reset held with both requests pending: nothing may be granted.
    rst = 1'b0;
    applyStimulus(1'b1, 16'h00aa, 16'hffff, 1'b1, 16'h00aa);
    repeat (2) begin
      @(negedge clk);
      checkOutput("reset_outputs", {str_grnt, done, ld_grnt, ld_vld, busy}, 5'b0);
      checkOutput("reset_ld_data", ld_data, 0);
    end
    nextCycle();
    rst = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b1, 16'h0042);
    waitGrant(1'b0, 1, g);
    checkOutput("release_busy", busy, 1);
    nextCycle();
    ld_req = 1'b0;
    waitDrain(LAT + 4);
    nextCycle();

    // Store with busy profile across grant, access and turnaround.
    applyStimulus(1'b1, 16'h00aa, 16'hffff, 1'b0, '0);
    waitGrant(1'b1, 4, g);
    checkOutput("store_grant_busy", busy, 1);
    nextCycle();
    str_req = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      checkOutput("store_busy", busy, 1);
      checkOutput("store_no_regrant", str_grnt, 0);
    end
    @(negedge clk);
    checkOutput("store_idle_busy", busy, 0);
    nextCycle();

    // Read back, then index aliasing and hold of ld_data.
    doLoad(16'h00aa);
    nextCycle();
    doStore(16'hbbbb, 16'h1111);
    doLoad(16'h00bb);
    @(negedge clk);
    checkOutput("ld_data_hold", ld_data, 16'h1111);
    nextCycle();

    // Starvation: both requests held continuously.
    applyStimulus(1'b1, 16'h0010, 16'h1234, 1'b1, 16'h00aa);
    expSeq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    n = 0;
    for (int k = 0; k < 60 && n < 6; k++) begin
      @(negedge clk);
      if (ld_grnt || str_grnt) begin
        isStoreSeq[n] = str_grnt;
        grantCyc[n]   = cyc;
        n++;
      end
    end
    checkOutput("starve_grant_count", n, 6);
    nextCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("starve_order%0d", i), isStoreSeq[i], expSeq[i]);
    end
    if (n == 6) begin
      checkOutput("load_to_load_gap", grantCyc[1] - grantCyc[0], LAT + 1);
      checkOutput("load_to_store_gap", grantCyc[3] - grantCyc[2], LAT + 1);
      checkOutput("store_to_load_gap", grantCyc[4] - grantCyc[3], LAT + 2);
    end
    waitDrain(LAT + 4);
    nextCycle();
    doLoad(16'h0010);
    nextCycle();

    // Store request held through done: no re-grant in the turnaround cycle.
    applyStimulus(1'b1, 16'h0020, 16'h0a0a, 1'b0, '0);
    waitGrant(1'b1, 4, g1);
    waitGrant(1'b1, LAT + 4, g2);
    checkOutput("store_holdover_spacing", g2 - g1, LAT + 2);
    nextCycle();
    str_req = 1'b0;
    waitDrain(LAT + 4);
    nextCycle();

    // Load request held: back-to-back load spacing.
    applyStimulus(1'b0, '0, '0, 1'b1, 16'h0020);
    waitGrant(1'b0, 4, g1);
    waitGrant(1'b0, LAT + 3, g2);
    checkOutput("load_holdover_spacing", g2 - g1, LAT + 1);
    nextCycle();
    ld_req = 1'b0;
    waitDrain(LAT + 4);
    nextCycle();

    // Reset in the cycle after a store grant aborts the write.
    applyStimulus(1'b1, 16'h00aa, 16'h5555, 1'b0, '0);
    waitGrant(1'b1, 4, g);
    nextCycle();
    str_req = 1'b0;
    rst     = 1'b0;
    nextCycle();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_ld_data", ld_data, 0);
    nextCycle();
    doLoad(16'h00aa);
    @(negedge clk);
    checkOutput("abort_old_data", ld_data, 16'hffff);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
